// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with 16x oversampling, presenting bytes on a valid/ack
// handshake with sticky overrun and a one-clock framing-error pulse.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for rxs low on a tick
// S_START | timing to mid start bit to reject glitches
// S_DATA  | sampling 8 data bits, LSB first
// S_STOP  | sampling the stop bit
// S_BREAK | stop bit was low; wait for the line to return high
module uart_rx_unit #(
  parameter int unsigned clk_freq = 50000000,
  parameter int unsigned baud     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned div    = clk_freq / (baud * 16);
  localparam int unsigned tick_w = (div > 1) ? $clog2(div) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  generate
    if (div < 1) begin : g_div_check
      $error("uart_rx_unit: clk_freq / (baud*16) must be at least 1");
    end
  endgenerate

  logic [1:0]        sync_q, sync_d;
  logic [tick_w-1:0] tcnt_q, tcnt_d;
  logic [2:0]        state_q, state_d;
  logic [3:0]        scnt_q, scnt_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [7:0]        sr_q, sr_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              ferr_q, ferr_d;
  logic              rxs, tick, byte_done, frame_bad;

  assign rxs = sync_q[1];

  always_comb begin
    sync_d = {sync_q[0], rx};
    tick   = (tcnt_q == tick_w'(div - 1));
    tcnt_d = tick ? '0 : tcnt_q + tick_w'(1);
  end

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bcnt_d    = bcnt_q;
    sr_d      = sr_q;
    byte_done = 1'b0;
    frame_bad = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs) begin
            state_d = S_START;
            scnt_d  = 4'd0;
          end
        end
        S_START: begin
          if (scnt_q == 4'd7) begin
            if (!rxs) begin
              state_d = S_DATA;
              scnt_d  = 4'd0;
              bcnt_d  = 3'd0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
        S_DATA: begin
          // scnt wraps 15 -> 0, so STOP is entered with scnt already at 0
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            sr_d   = {rxs, sr_q[7:1]};
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            byte_done = rxs;
            frame_bad = !rxs;
            state_d   = rxs ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          if (rxs) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    ferr_d    = frame_bad;
    if (rx_ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    // an ack on the completion edge frees the register for the new byte
    if (byte_done) begin
      if (!valid_q || rx_ack) begin
        data_d  = sr_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      tcnt_q    <= '0;
      state_q   <= S_IDLE;
      scnt_q    <= 4'd0;
      bcnt_q    <= 3'd0;
      sr_q      <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      tcnt_q    <= tcnt_d;
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: doc/uart_rx_unit.md
# uart_rx_unit

Serial receiver that sits directly upstream of the ARC datapath's I/O port. It takes the asynchronous `rx` pin of `system` and turns it into 8-bit bytes: 8N1 framing, LSB first, 16x oversampling. Each completed byte is presented on a valid/ack handshake to the datapath's memory-mapped input register, with overrun and framing-error flags.

## Interface
- `clk_freq`, default 50000000: system clock frequency in Hz.
- `baud`, default 115200: serial bit rate.
- Derived constant `div = clk_freq / (baud*16)`, integer division. `div` must be at least 1; this is checked at elaboration.

Ports:
- `clk`, in, 1: single system clock, rising-edge.
- `rst`, in, 1: asynchronous, active-low reset (0 = reset asserted).
- `rx`, in, 1: serial line, asynchronous to `clk`, idle high.
- `rx_data`, out, 8: last received byte.
- `rx_valid`, out, 1: `rx_data` holds an unconsumed byte.
- `rx_ack`, in, 1: one-cycle consume strobe from the datapath.
- `rx_overrun`, out, 1: sticky; a byte was lost while `rx_valid` was set.
- `rx_frame_err`, out, 1: one-cycle pulse when a stop bit is sampled low.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value `rxs`.
- **Tick generator.** A free-running counter from 0 to `div-1` produces a one-clock `tick` on wrap. The counter resets to 0.
- **State machine** (`scnt` is a 4-bit sub-bit tick counter, `bcnt` a 3-bit bit counter):
  - IDLE: when `rxs`==0 is seen on a tick, go to START with `scnt`=0.
  - START: count ticks. At `scnt`==7 (mid start bit), if `rxs`==0 go to DATA with `scnt`=0 and `bcnt`=0. Otherwise treat it as a glitch and return to IDLE.
  - DATA: at each `scnt`==15, shift `rxs` into the shift register MSB-first (`sr <= {rxs, sr[7:1]}`), so the bytes end up LSB-first. After `bcnt`==7 is sampled, go to STOP.
  - STOP: at `scnt`==15, sample the stop bit.
    - If `rxs`==1: load `rx_data <= sr`, set `rx_valid`, go to IDLE.
    - If `rxs`==0: pulse `rx_frame_err`, discard the byte (`rx_data` and `rx_valid` unchanged), go to BREAK.
  - BREAK: wait for `rxs`==1 on a tick, then go to IDLE. This stops a held-low line from re-triggering.
- **Handshake.**
  - `rx_ack`==1 while `rx_valid`==1 clears `rx_valid` and `rx_overrun` on the next edge.
  - `rx_ack` while `rx_valid`==0 is ignored.
- **Overrun.** If a good stop bit completes while `rx_valid`==1 and `rx_ack`==0:
  - the new byte is dropped;
  - `rx_data` keeps the old byte;
  - `rx_overrun` is set.
- **Simultaneous ack and byte completion.** The new byte is loaded and `rx_valid` stays 1. No overrun.
- **Reset.** Reset mid-frame aborts immediately. After release the block waits in IDLE for the next falling edge.

## Timing
- **Reset values:** `rx_data`=8'h00, `rx_valid`=0, `rx_overrun`=0, `rx_frame_err`=0; state IDLE; synchronizer flops = 1.
- **Detection delay:** a start edge on `rx` is seen after 2 clocks of synchronizer plus up to one tick period.
- **Sampling points:** mid-bit, at 8 + 16·k ticks after detection (k = 1..9, where k=9 is the stop bit).
- **Output latency:**
  - `rx_valid` rises on the clock edge after the stop-bit sample tick, about 152 ticks after detection.
  - `rx_frame_err` is high for exactly one clock at that same edge.
- **Back-to-back frames:** IDLE is re-entered at mid stop bit, so a start bit immediately after the stop bit is received correctly.
- **No combinational paths** from inputs to outputs.

## Test plan
All scenarios use `clk_freq`=50000000 and `baud`=3125000, giving `div`=1 and a bit time of 16 clocks.
1. **Reset.** Hold `rst`=0 and toggle `rx`. Outputs stay 00/0/0/0. Release reset with `rx`=1: no activity.
2. **Single byte.** Send 0xA5. `rx_data`=8'hA5 and `rx_valid`=1 within 152±3 clocks of the start edge. Pulse `rx_ack`: `rx_valid`=0 next clock.
3. **Back-to-back with overrun.** Send 0x3C then 0xC3 with no ack. `rx_data` stays 8'h3C and `rx_overrun`=1. `rx_ack` clears both flags.
4. **Framing error.** Send 0x55 with the stop bit low, then hold `rx` low 40 clocks and release. Expect a one-clock `rx_frame_err`, `rx_valid` stays 0, and no byte is received during the hold. A following 0x0F is received correctly.
5. **Start glitch.** Pulse `rx` low for 4 clocks. No `rx_valid` and no `rx_frame_err`; the FSM is back in IDLE.
6. **Ack on the completion edge, and reset mid-frame.**
   - Assert `rx_ack` on the exact edge the second byte completes: new byte loaded, `rx_valid`=1, `rx_overrun`=0.
   - Assert `rst` during the data bits of a frame: outputs reset, and the partial frame never appears.
